// File: rtl/game_frame_sched.sv
// Per-frame scheduler: sequences bird, tube and collision engines on
// each vsync fall, and owns score, speed, gravity pacing and pause.
module game_frame_sched #(
    parameter int GRAV_DIV   = 2,
    parameter int SPEED_INIT = 1,
    parameter int SPEED_MAX  = 4,
    parameter int SCORE_STEP = 8,
    parameter int TIMEOUT    = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vs_in,
    input  logic        run,
    input  logic [7:0]  rx_data,
    input  logic        rx_data_valid,
    output logic        bird_req,
    input  logic        bird_ack,
    output logic        fall_en,
    output logic        tube_req,
    input  logic        tube_ack,
    output logic [2:0]  tube_step,
    output logic        col_req,
    input  logic        col_ack,
    input  logic        col_hit,
    input  logic        score_inc,
    output logic [15:0] score,
    output logic [2:0]  speed,
    output logic        paused,
    output logic        game_over,
    output logic        overrun,
    output logic [15:0] frame_cnt
);

    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int GW = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;

    typedef enum logic [1:0] {IDLE, BIRD, TUBE, COLL} state_t;

    state_t state, state_nx;

    logic          vs_r, rxv_r, run_r, dead;
    logic          frame_edge, rx_edge, run_rise, frame_ok;
    logic          start, done, tmo, ack, drop;
    logic [WW-1:0] wait_cnt;
    logic [GW-1:0] grav;
    logic [16:0]   spd_sum;
    logic [2:0]    speed_calc;

    assign frame_edge = vs_r & ~vs_in;
    assign rx_edge    = rx_data_valid & ~rxv_r;
    assign run_rise   = run & ~run_r;
    assign frame_ok   = frame_edge & run & ~paused & ~dead;

    assign bird_req = (state == BIRD);
    assign tube_req = (state == TUBE);
    assign col_req  = (state == COLL);

    // A vsync fall that coincides with the closing col_ack is not a drop.
    assign drop = frame_edge & run & (state != IDLE)
                & ~((state == COLL) & col_ack);

    assign spd_sum = 17'(score / 16'(SCORE_STEP)) + 17'(SPEED_INIT);
    assign speed_calc = (spd_sum > 17'(SPEED_MAX)) ?
                        3'(SPEED_MAX) : spd_sum[2:0];

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        done     = 1'b0;
        ack      = 1'b0;
        tmo      = 1'b0;
        unique case (state)
            IDLE: begin
                if (frame_ok) begin
                    state_nx = BIRD;
                    start    = 1'b1;
                end
            end
            BIRD: begin
                ack = bird_ack;
                if (bird_ack) state_nx = TUBE;
            end
            TUBE: begin
                ack = tube_ack;
                if (tube_ack) state_nx = COLL;
            end
            COLL: begin
                ack = col_ack;
                if (col_ack) begin
                    done = 1'b1;
                    if (frame_ok && !col_hit) begin
                        state_nx = BIRD;
                        start    = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        if (state != IDLE && !ack && wait_cnt == WW'(TIMEOUT - 1)) begin
            tmo      = 1'b1;
            state_nx = IDLE;
        end
        if (!run) begin
            state_nx = IDLE;
            start    = 1'b0;
            done     = 1'b0;
            tmo      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_r      <= 1'b0;
            rxv_r     <= 1'b0;
            run_r     <= 1'b0;
            dead      <= 1'b0;
            wait_cnt  <= '0;
            grav      <= '0;
            fall_en   <= 1'b0;
            tube_step <= 3'(SPEED_INIT);
            speed     <= 3'(SPEED_INIT);
            score     <= 16'd0;
            paused    <= 1'b0;
            game_over <= 1'b0;
            overrun   <= 1'b0;
            frame_cnt <= 16'd0;
        end else begin
            vs_r      <= vs_in;
            rxv_r     <= rx_data_valid;
            run_r     <= run;
            game_over <= 1'b0;
            speed     <= speed_calc;

            if (state_nx != state) begin
                wait_cnt <= '0;
            end else if (state != IDLE) begin
                wait_cnt <= wait_cnt + WW'(1);
            end

            if (start) begin
                tube_step <= speed;
                fall_en   <= (grav == GW'(GRAV_DIV - 1));
                grav      <= (grav == GW'(GRAV_DIV - 1)) ?
                             '0 : grav + GW'(1);
            end

            if (done) begin
                frame_cnt <= frame_cnt + 16'd1;
                if (col_hit) begin
                    game_over <= 1'b1;
                    dead      <= 1'b1;
                end
            end

            if (score_inc && score != 16'hFFFF) score <= score + 16'd1;
            if (drop || tmo) overrun <= 1'b1;

            if (rx_edge && rx_data == 8'h70 && run) paused <= ~paused;

            if (run_rise) begin
                score     <= 16'd0;
                frame_cnt <= 16'd0;
                overrun   <= 1'b0;
            end

            if (!run) begin
                paused <= 1'b0;
                dead   <= 1'b0;
                grav   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_game_frame_sched.sv
// Directed bench for game_frame_sched: handshake order, overrun,
// speed levels, game over, pause, ack timeout and reset.
module tb_game_frame_sched;

    logic        clk;
    logic        rst;
    logic        vs_in;
    logic        run;
    logic [7:0]  rx_data;
    logic        rx_data_valid;
    logic        bird_req;
    logic        bird_ack;
    logic        fall_en;
    logic        tube_req;
    logic        tube_ack;
    logic [2:0]  tube_step;
    logic        col_req;
    logic        col_ack;
    logic        col_hit;
    logic        score_inc;
    logic [15:0] score;
    logic [2:0]  speed;
    logic        paused;
    logic        game_over;
    logic        overrun;
    logic [15:0] frame_cnt;

    int tests = 0;
    int fails = 0;

    game_frame_sched dut (
        .clk           (clk),
        .rst           (rst),
        .vs_in         (vs_in),
        .run           (run),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .bird_req      (bird_req),
        .bird_ack      (bird_ack),
        .fall_en       (fall_en),
        .tube_req      (tube_req),
        .tube_ack      (tube_ack),
        .tube_step     (tube_step),
        .col_req       (col_req),
        .col_ack       (col_ack),
        .col_hit       (col_hit),
        .score_inc     (score_inc),
        .score         (score),
        .speed         (speed),
        .paused        (paused),
        .game_over     (game_over),
        .overrun       (overrun),
        .frame_cnt     (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic vs_fall();
        vs_in = 1'b1;
        tick();
        vs_in = 1'b0;
        tick();
    endtask

    task automatic bird_phase();
        tick();
        tick();
        bird_ack = 1'b1;
        tick();
        bird_ack = 1'b0;
    endtask

    task automatic tube_phase();
        tick();
        tick();
        tube_ack = 1'b1;
        tick();
        tube_ack = 1'b0;
    endtask

    task automatic col_phase(input logic hit);
        tick();
        tick();
        col_ack = 1'b1;
        col_hit = hit;
        tick();
        col_ack = 1'b0;
        col_hit = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rx_data = b;
        rx_data_valid = 1'b1;
        tick();
        rx_data_valid = 1'b0;
        tick();
    endtask

    task automatic toggle_run();
        run = 1'b0;
        tick();
        run = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        vs_in = 1'b0;
        run = 1'b0;
        rx_data = 8'h00;
        rx_data_valid = 1'b0;
        bird_ack = 1'b0;
        tube_ack = 1'b0;
        col_ack = 1'b0;
        col_hit = 1'b0;
        score_inc = 1'b0;
        tick();
        tick();

        chk("rst_bird_req", bird_req, 0);
        chk("rst_tube_req", tube_req, 0);
        chk("rst_col_req", col_req, 0);
        chk("rst_speed", speed, 1);
        chk("rst_tube_step", tube_step, 1);
        chk("rst_score", score, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_paused", paused, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_fall_en", fall_en, 0);

        rst = 1'b0;
        run = 1'b1;
        tick();

        // frame 1
        vs_in = 1'b1;
        tick();
        vs_in = 1'b0;
        chk("f1_pre_bird", bird_req, 0);
        tick();
        chk("f1_bird_req", bird_req, 1);
        chk("f1_tube_idle", tube_req, 0);
        chk("f1_fall_en", fall_en, 0);
        bird_phase();
        chk("f1_bird_drop", bird_req, 0);
        chk("f1_tube_req", tube_req, 1);
        tube_phase();
        chk("f1_tube_drop", tube_req, 0);
        chk("f1_col_req", col_req, 1);
        col_phase(1'b0);
        chk("f1_col_drop", col_req, 0);
        chk("f1_frame_cnt", frame_cnt, 1);
        chk("f1_game_over", game_over, 0);

        // frame 2 with an extra vsync fall during TUBE
        vs_fall();
        chk("f2_fall_en", fall_en, 1);
        bird_phase();
        chk("f2_tube_req", tube_req, 1);
        vs_fall();
        chk("f2_overrun", overrun, 1);
        chk("f2_still_tube", tube_req, 1);
        tube_ack = 1'b1;
        tick();
        tube_ack = 1'b0;
        chk("f2_fall_hold", fall_en, 1);
        col_phase(1'b0);
        chk("f2_frame_cnt", frame_cnt, 2);
        chk("f2_idle", bird_req, 0);

        toggle_run();
        chk("rr_overrun", overrun, 0);
        chk("rr_frame_cnt", frame_cnt, 0);

        // vsync fall on the same cycle as col_ack
        vs_fall();
        chk("f3_fall_en", fall_en, 0);
        bird_phase();
        tube_phase();
        tick();
        vs_in = 1'b1;
        tick();
        vs_in = 1'b0;
        col_ack = 1'b1;
        tick();
        col_ack = 1'b0;
        chk("b2b_bird_req", bird_req, 1);
        chk("b2b_col_req", col_req, 0);
        chk("b2b_overrun", overrun, 0);
        chk("b2b_frame_cnt", frame_cnt, 1);
        chk("b2b_fall_en", fall_en, 1);
        bird_phase();
        tube_phase();
        col_phase(1'b0);
        chk("b2b_frame_cnt2", frame_cnt, 2);

        // score and speed levels
        score_inc = 1'b1;
        repeat (17) tick();
        score_inc = 1'b0;
        tick();
        chk("s17_score", score, 17);
        chk("s17_speed", speed, 3);
        chk("s17_step_old", tube_step, 1);
        vs_fall();
        chk("s17_step_new", tube_step, 3);
        bird_phase();
        tube_phase();
        col_phase(1'b0);
        score_inc = 1'b1;
        repeat (23) tick();
        score_inc = 1'b0;
        tick();
        chk("s40_score", score, 40);
        chk("s40_speed", speed, 4);
        chk("s40_step_old", tube_step, 3);

        // hit ends the game
        vs_fall();
        chk("hit_step", tube_step, 4);
        bird_phase();
        tube_phase();
        col_phase(1'b1);
        chk("hit_game_over", game_over, 1);
        chk("hit_frame_cnt", frame_cnt, 4);
        tick();
        chk("hit_go_pulse", game_over, 0);
        vs_fall();
        chk("dead_no_req", bird_req, 0);
        chk("dead_no_overrun", overrun, 0);
        toggle_run();
        chk("restart_score", score, 0);
        chk("restart_frame_cnt", frame_cnt, 0);
        tick();
        chk("restart_speed", speed, 1);
        vs_fall();
        chk("restart_bird_req", bird_req, 1);
        bird_phase();
        tube_phase();
        col_phase(1'b0);
        chk("restart_frame_cnt1", frame_cnt, 1);

        // pause
        rx_byte(8'h70);
        chk("pause_on", paused, 1);
        vs_fall();
        chk("pause_no_req", bird_req, 0);
        rx_byte(8'h70);
        chk("pause_off", paused, 0);
        rx_byte(8'h30);
        chk("pause_other", paused, 0);
        vs_fall();
        chk("resume_bird_req", bird_req, 1);

        // bird_ack withheld
        repeat (1000) tick();
        chk("tmo_waiting", bird_req, 1);
        chk("tmo_no_ovr_yet", overrun, 0);
        repeat (30) tick();
        chk("tmo_bird_drop", bird_req, 0);
        chk("tmo_tube_idle", tube_req, 0);
        chk("tmo_overrun", overrun, 1);
        chk("tmo_frame_cnt", frame_cnt, 1);

        // reset in the middle of TUBE
        vs_fall();
        bird_phase();
        chk("mid_tube_req", tube_req, 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_tube", tube_req, 0);
        chk("mid_rst_overrun", overrun, 0);
        chk("mid_rst_frame", frame_cnt, 0);
        chk("mid_rst_score", score, 0);
        chk("mid_rst_speed", speed, 1);
        chk("mid_rst_step", tube_step, 1);
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/game_frame_sched.md
Name: game_frame_sched

Overview:
Per-frame update scheduler for the Flappy Bird game. On each vsync falling edge it sequences three update engines in a fixed order over req/ack handshakes: bird physics, tube scroll, collision check. It also owns score, speed level, gravity pacing, pause (UART command) and overrun detection. It sits between the video timing, the UART receiver and the game datapath.

Parameters:
GRAV_DIV, 2, bird falls 1 px every GRAV_DIV frames (>=1)
SPEED_INIT, 1, tube scroll px/frame at score 0
SPEED_MAX, 4, speed ceiling (<=7)
SCORE_STEP, 8, score points per speed increment
TIMEOUT, 1023, max cycles waiting for any single ack

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
vs_in  in  1  vsync; falling edge = frame start
run  in  1  game in GAME state
rx_data  in  8  UART byte
rx_data_valid  in  1  UART byte valid (level, edge-detected here)
bird_req  out  1  request bird update
bird_ack  in  1  bird update done
fall_en  out  1  bird must fall this frame (valid while bird_req)
tube_req  out  1  request tube scroll
tube_ack  in  1  tube scroll done
tube_step  out  3  px to scroll this frame (= speed)
col_req  out  1  request collision check
col_ack  in  1  check done
col_hit  in  1  collision result, sampled with col_ack
score_inc  in  1  one-cycle pulse: tube passed
score  out  16  current score
speed  out  3  current speed level
paused  out  1  pause active
game_over  out  1  one-cycle pulse on hit
overrun  out  1  sticky: frame dropped or ack timeout
frame_cnt  out  16  completed frames, wraps

Behaviour:
- Reset: all outputs 0 except speed=SPEED_INIT, tube_step=SPEED_INIT; FSM=IDLE; grav counter=0; dead=0.
- Edge detect: vs_r<=vs_in; frame edge = vs_r & ~vs_in. rx edge = rx_data_valid & ~rxv_r.
- FSM states IDLE, BIRD, TUBE, COLL. Exactly one req high in BIRD/TUBE/COLL, none in IDLE.
- IDLE->BIRD on frame edge when run & ~paused & ~dead; bird_req high the next cycle (1-cycle latency).
- BIRD->TUBE on bird_ack; TUBE->COLL on tube_ack; COLL->IDLE on col_ack. Req drops the cycle after its ack is sampled; the next req rises in that same cycle. Ack while own req is low is ignored.
- On col_ack: frame_cnt+1. If col_hit: game_over pulse next cycle, dead<=1.
- Frame edge in COLL in the same cycle as col_ack: accepted, COLL->BIRD directly. Frame edge in any other non-IDLE cycle: dropped, overrun<=1.
- Wait counter clears on each state entry; if it reaches TIMEOUT without ack: overrun<=1, ->IDLE, frame not counted.
- fall_en: grav counter increments per started frame, wraps at GRAV_DIV-1; fall_en=1 for the frame in which counter==GRAV_DIV-1 (before increment). Held stable through the frame.
- score: +1 on score_inc, saturates at 0xFFFF. speed = min(SPEED_MAX, SPEED_INIT + score/SCORE_STEP), registered 1 cycle after score; tube_step latched from speed at IDLE->BIRD and held for the frame.
- Pause: rx edge with rx_data==8'h70 ('p') while run toggles paused. Paused blocks new frames only; an in-progress frame completes.
- run low: FSM ->IDLE next cycle, all reqs drop, no overrun; paused, dead, grav counter cleared. Rising edge of run clears score, frame_cnt, overrun.
- rst mid-frame: reqs low the following cycle, all state per reset.

Test Plan:
- Single frame, run=1, acks returned 2 cycles after each req -> bird_req rises 1 cycle after vs edge, order bird/tube/col, frame_cnt=1, fall_en=0 frame 1 and 1 frame 2 (GRAV_DIV=2).
- Second vs edge while in TUBE -> overrun=1, frame_cnt unchanged; vs edge same cycle as col_ack -> bird_req next cycle, overrun stays 0.
- 17 score_inc pulses -> score=17, speed=3; 40 pulses -> speed=4 (capped); tube_step changes only at next frame start.
- col_ack with col_hit=1 -> game_over one-cycle pulse, later vs edges ignored until run toggles 0->1, which clears score to 0.
- rx 0x70 then vs edge -> no req, paused=1; 0x70 again -> next vs edge starts frame; rx 0x30 -> no effect.
- Hold bird_ack low 1023 cycles -> overrun=1, bird_req low, FSM IDLE; rst asserted mid-TUBE -> tube_req low next cycle, all outputs at reset values.
